// File: rtl/mem_scheduler.sv
// Arbitrates fetch, load and store requesters onto the single byte-serial memory
// controller: store > load > fetch, with a forced fetch win after repeated losses.
module mem_scheduler #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        ld_req,
   input  logic [6:0]  ld_op,
   input  logic [31:0] ld_addr,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   input  logic        st_req,
   input  logic [6:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_done,
   output logic        fetch_enable,
   output logic [31:0] inst_addr,
   output logic        lsb_enable,
   output logic        lsb_r_or_w,
   output logic [6:0]  op,
   output logic [31:0] lsb_addr,
   output logic [31:0] lsb_data,
   input  logic        i_cache_valid,
   input  logic [31:0] i_cache_data,
   input  logic        lsb_valid,
   input  logic [31:0] read_data
);

   typedef enum logic [2:0] {IDLE, BUSY_F, BUSY_L, BUSY_S, DRAIN} state_t;

   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_force, grant_f, grant_l, grant_s;
   logic             fetch_done, lsb_done, pulse_if, pulse_ld, pulse_st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (rdy)
         state <= state_nxt;
   end

   // A flushed load/fetch cannot be aborted at the controller, so it drains instead.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_f)
               state_nxt = BUSY_F;
            else if (grant_s)
               state_nxt = BUSY_S;
            else if (grant_l)
               state_nxt = BUSY_L;
         end
         BUSY_F: begin
            if (fetch_done)
               state_nxt = IDLE;
            else if (flush)
               state_nxt = DRAIN;
         end
         BUSY_L: begin
            if (lsb_done)
               state_nxt = IDLE;
            else if (flush)
               state_nxt = DRAIN;
         end
         BUSY_S: begin
            if (lsb_done)
               state_nxt = IDLE;
         end
         DRAIN: begin
            if (fetch_done || lsb_done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      starve_force = 1'b0;
      grant_f      = 1'b0;
      grant_l      = 1'b0;
      grant_s      = 1'b0;
      fetch_done   = fetch_enable && i_cache_valid;
      lsb_done     = lsb_enable && lsb_valid;
      pulse_if     = 1'b0;
      pulse_ld     = 1'b0;
      pulse_st     = 1'b0;
      if (state == IDLE) begin
         starve_force = (starve_cnt >= LIMIT) && if_req && !flush;
         grant_s      = st_req && !starve_force;
         grant_l      = ld_req && !flush && !st_req && !starve_force;
         grant_f      = if_req && !flush && (starve_force || (!st_req && !ld_req));
      end
      pulse_if = (state == BUSY_F) && fetch_done && !flush;
      pulse_ld = (state == BUSY_L) && lsb_done && !flush;
      pulse_st = (state == BUSY_S) && lsb_done;
   end

   // Request fields are captured at grant and held until the controller strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid     <= 1'b0;
         if_data      <= '0;
         ld_valid     <= 1'b0;
         ld_data      <= '0;
         st_done      <= 1'b0;
         fetch_enable <= 1'b0;
         inst_addr    <= '0;
         lsb_enable   <= 1'b0;
         lsb_r_or_w   <= 1'b0;
         op           <= '0;
         lsb_addr     <= '0;
         lsb_data     <= '0;
         starve_cnt   <= '0;
      end else if (rdy) begin
         if_valid <= pulse_if;
         ld_valid <= pulse_ld;
         st_done  <= pulse_st;
         if (pulse_if)
            if_data <= i_cache_data;
         if (pulse_ld)
            ld_data <= read_data;

         if (grant_f) begin
            fetch_enable <= 1'b1;
            inst_addr    <= if_addr;
         end else if (fetch_done) begin
            fetch_enable <= 1'b0;
         end

         if (grant_s) begin
            lsb_enable <= 1'b1;
            lsb_r_or_w <= 1'b0;
            op         <= st_op;
            lsb_addr   <= st_addr;
            lsb_data   <= st_data;
         end else if (grant_l) begin
            lsb_enable <= 1'b1;
            lsb_r_or_w <= 1'b1;
            op         <= ld_op;
            lsb_addr   <= ld_addr;
         end else if (lsb_done) begin
            lsb_enable <= 1'b0;
         end

         if (flush || !if_req || grant_f)
            starve_cnt <= '0;
         else if ((grant_l || grant_s) && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler: stimulus pushes expected responses, a monitor
// pops and compares them whenever a response strobe appears.
module tb_mem_scheduler;

   localparam logic [1:0] K_IF = 2'd1;
   localparam logic [1:0] K_LD = 2'd2;
   localparam logic [1:0] K_ST = 2'd3;
   localparam logic [6:0] OP_LW = 7'h02;
   localparam logic [6:0] OP_SB = 7'h20;
   localparam logic [6:0] OP_SW = 7'h22;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        flush = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_valid;
   logic [31:0] if_data;
   logic        ld_req = 1'b0;
   logic [6:0]  ld_op = '0;
   logic [31:0] ld_addr = '0;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        st_req = 1'b0;
   logic [6:0]  st_op = '0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        st_done;
   logic        fetch_enable;
   logic [31:0] inst_addr;
   logic        lsb_enable;
   logic        lsb_r_or_w;
   logic [6:0]  op;
   logic [31:0] lsb_addr;
   logic [31:0] lsb_data;
   logic        i_cache_valid = 1'b0;
   logic [31:0] i_cache_data = '0;
   logic        lsb_valid = 1'b0;
   logic [31:0] read_data = '0;

   int    checks = 0;
   int    fails = 0;
   resp_t exp_q[$];

   mem_scheduler #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
      .ld_req(ld_req), .ld_op(ld_op), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_data(ld_data),
      .st_req(st_req), .st_op(st_op), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
      .fetch_enable(fetch_enable), .inst_addr(inst_addr),
      .lsb_enable(lsb_enable), .lsb_r_or_w(lsb_r_or_w), .op(op),
      .lsb_addr(lsb_addr), .lsb_data(lsb_data),
      .i_cache_valid(i_cache_valid), .i_cache_data(i_cache_data),
      .lsb_valid(lsb_valid), .read_data(read_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic l, input logic f);
      st_req = s;
      ld_req = l;
      if_req = f;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectResp(input logic [1:0] kind, input logic [31:0] data);
      exp_q.push_back('{kind: kind, data: data});
   endtask

   task automatic scoreCheck(input logic [1:0] kind, input logic [31:0] data);
      resp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("[TB] FAIL unexpected_strobe: got kind %0d data 0x%0h, expected no response", kind, data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.data !== data) begin
            fails++;
            $display("[TB] FAIL response: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                     kind, data, e.kind, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (if_valid)
            scoreCheck(K_IF, if_data);
         if (ld_valid)
            scoreCheck(K_LD, ld_data);
         if (st_done)
            scoreCheck(K_ST, 32'h0);
      end
   end

   initial begin
      #1 rst = 1'b1;
      tick(2);
      checkOutput("reset_flags", {26'h0, fetch_enable, lsb_enable, lsb_r_or_w, if_valid, ld_valid, st_done}, 32'h0);
      checkOutput("reset_inst_addr", inst_addr, 32'h0);
      checkOutput("reset_lsb_addr", lsb_addr, 32'h0);
      checkOutput("reset_lsb_data", lsb_data, 32'h0);
      checkOutput("reset_op", {25'h0, op}, 32'h0);
      rst = 1'b0;
      tick(1);

      $display("[TB] priority: store, then load, then fetch");
      applyStimulus(1, 1, 1);
      st_op = OP_SW; st_addr = 32'h100; st_data = 32'hDEADBEEF;
      ld_op = OP_LW; ld_addr = 32'h200; if_addr = 32'h40;
      tick(1);
      checkOutput("grant_store_en", {29'h0, fetch_enable, lsb_enable, lsb_r_or_w}, 32'b010);
      checkOutput("grant_store_addr", lsb_addr, 32'h100);
      checkOutput("grant_store_data", lsb_data, 32'hDEADBEEF);
      checkOutput("grant_store_op", {25'h0, op}, {25'h0, OP_SW});
      expectResp(K_ST, 32'h0);
      lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0; st_req = 1'b0;
      checkOutput("store_release", {30'h0, fetch_enable, lsb_enable}, 32'h0);
      tick(1);
      checkOutput("grant_load_en", {29'h0, fetch_enable, lsb_enable, lsb_r_or_w}, 32'b011);
      checkOutput("grant_load_addr", lsb_addr, 32'h200);
      checkOutput("grant_load_op", {25'h0, op}, {25'h0, OP_LW});
      expectResp(K_LD, 32'h12345678);
      read_data = 32'h12345678; lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0; ld_req = 1'b0;
      checkOutput("load_release", {30'h0, fetch_enable, lsb_enable}, 32'h0);
      tick(1);
      checkOutput("grant_fetch_en", {30'h0, fetch_enable, lsb_enable}, 32'b10);
      checkOutput("grant_fetch_addr", inst_addr, 32'h40);
      expectResp(K_IF, 32'hCAFEF00D);
      i_cache_data = 32'hCAFEF00D; i_cache_valid = 1'b1;
      tick(1);
      i_cache_valid = 1'b0; if_req = 1'b0;
      checkOutput("fetch_release", {30'h0, fetch_enable, lsb_enable}, 32'h0);
      tick(1);
      checkOutput("strobes_single_cycle", {29'h0, if_valid, ld_valid, st_done}, 32'h0);

      $display("[TB] fetch starvation override");
      applyStimulus(0, 1, 1);
      if_addr = 32'h80;
      for (int i = 0; i < 8; i++) begin
         ld_addr = 32'h300 + 32'(i * 4);
         tick(1);
         checkOutput("starve_load_grant", {30'h0, fetch_enable, lsb_enable}, 32'b01);
         checkOutput("starve_load_addr", lsb_addr, 32'h300 + 32'(i * 4));
         expectResp(K_LD, 32'hA0000000 + 32'(i));
         read_data = 32'hA0000000 + 32'(i); lsb_valid = 1'b1;
         tick(1);
         lsb_valid = 1'b0;
      end
      ld_addr = 32'h340;
      tick(1);
      checkOutput("starve_fetch_forced", {30'h0, fetch_enable, lsb_enable}, 32'b10);
      checkOutput("starve_fetch_addr", inst_addr, 32'h80);
      expectResp(K_IF, 32'h0BADCAFE);
      i_cache_data = 32'h0BADCAFE; i_cache_valid = 1'b1;
      tick(1);
      i_cache_valid = 1'b0; if_addr = 32'h84;
      tick(1);
      checkOutput("starve_cleared_load_wins", {30'h0, fetch_enable, lsb_enable}, 32'b01);
      checkOutput("starve_ninth_load_addr", lsb_addr, 32'h340);
      expectResp(K_LD, 32'h00000909);
      read_data = 32'h00000909; lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0; ld_req = 1'b0;
      tick(1);
      checkOutput("starve_late_fetch", {30'h0, fetch_enable, lsb_enable}, 32'b10);
      checkOutput("starve_late_fetch_addr", inst_addr, 32'h84);
      expectResp(K_IF, 32'h00000084);
      i_cache_data = 32'h00000084; i_cache_valid = 1'b1;
      tick(1);
      i_cache_valid = 1'b0; if_req = 1'b0;
      tick(1);

      $display("[TB] flush handling");
      applyStimulus(0, 1, 0);
      ld_addr = 32'h400; flush = 1'b1;
      tick(1);
      checkOutput("flush_idle_no_grant", {30'h0, fetch_enable, lsb_enable}, 32'h0);
      flush = 1'b0;
      tick(1);
      checkOutput("flush_load_grant", {31'h0, lsb_enable}, 32'h1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0; ld_req = 1'b0;
      checkOutput("drain_hold_en", {31'h0, lsb_enable}, 32'h1);
      tick(2);
      checkOutput("drain_still_held", {30'h0, lsb_enable, ld_valid}, 32'b10);
      read_data = 32'h00000BAD; lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0;
      checkOutput("drain_release", {30'h0, lsb_enable, ld_valid}, 32'h0);
      tick(1);
      checkOutput("drain_no_pulse", {31'h0, ld_valid}, 32'h0);

      ld_req = 1'b1; ld_addr = 32'h410;
      tick(1);
      checkOutput("coincident_grant", {31'h0, lsb_enable}, 32'h1);
      flush = 1'b1; lsb_valid = 1'b1; read_data = 32'h00000BAD;
      tick(1);
      flush = 1'b0; lsb_valid = 1'b0; ld_req = 1'b0;
      checkOutput("coincident_discard", {30'h0, lsb_enable, ld_valid}, 32'h0);

      applyStimulus(1, 0, 0);
      st_op = OP_SB; st_addr = 32'h500; st_data = 32'h11223344;
      tick(1);
      checkOutput("store_after_coincident", {29'h0, fetch_enable, lsb_enable, lsb_r_or_w}, 32'b010);
      checkOutput("store_flush_addr", lsb_addr, 32'h500);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      checkOutput("store_flush_hold", {31'h0, lsb_enable}, 32'h1);
      expectResp(K_ST, 32'h0);
      lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0; st_req = 1'b0;
      checkOutput("store_flush_done", {31'h0, st_done}, 32'h1);
      tick(1);

      $display("[TB] rdy freeze");
      applyStimulus(0, 0, 1);
      if_addr = 32'h600;
      tick(1);
      checkOutput("rdy_fetch_grant", inst_addr, 32'h600);
      i_cache_data = 32'h55AA55AA; i_cache_valid = 1'b1; rdy = 1'b0;
      st_req = 1'b1; st_addr = 32'h700; st_op = OP_SW; st_data = 32'h77777777;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checkOutput("rdy_freeze", {29'h0, fetch_enable, lsb_enable, if_valid}, 32'b100);
      end
      expectResp(K_IF, 32'h55AA55AA);
      rdy = 1'b1;
      tick(1);
      i_cache_valid = 1'b0; if_req = 1'b0;
      checkOutput("rdy_resume", {30'h0, fetch_enable, if_valid}, 32'b01);

      $display("[TB] asynchronous reset mid-store");
      tick(1);
      checkOutput("pre_reset_store", lsb_addr, 32'h700);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset_flags", {26'h0, fetch_enable, lsb_enable, lsb_r_or_w, if_valid, ld_valid, st_done}, 32'h0);
      checkOutput("async_reset_addr", lsb_addr, 32'h0);
      checkOutput("async_reset_data", lsb_data, 32'h0);
      checkOutput("async_reset_if_data", if_data, 32'h0);
      st_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1, 0);
      ld_addr = 32'h800;
      tick(1);
      checkOutput("post_reset_load_grant", {29'h0, fetch_enable, lsb_enable, lsb_r_or_w}, 32'b011);
      expectResp(K_LD, 32'h80808080);
      read_data = 32'h80808080; lsb_valid = 1'b1;
      tick(1);
      lsb_valid = 1'b0; ld_req = 1'b0;
      tick(2);
      checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
